pipe_hazard_ctrl_v2: RTL and testbench
======================================

Name: pipe_hazard_ctrl_v2

Overview:
- Second-generation hazard/pipeline-control unit for the 5-stage Y86-64 core (F/D/E/M/W).
- Generates stall/bubble/set_cc controls from decode/execute/memory/writeback state.
- Adds behaviour the combinational generation lacks: multi-cycle memory stall handshake, a parametrised ret refill-delay counter, a sticky exception/halt state machine, and saturating stall/bubble performance counters.
- Instruction and status encodings come from define.v.

Parameters:
- REG_W, 4, register-ID width of srcA/srcB/dstM.
- ICODE_W, 4, icode width.
- STAT_W, 3, status-code width.
- RET_LAT, 3, extra fetch-stall cycles after a ret leaves M; range 0..15.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- D_icode_i  in  ICODE_W  icode in D
- d_srcA_i  in  REG_W  decode srcA (RNONE = 4'hF)
- d_srcB_i  in  REG_W  decode srcB
- E_icode_i  in  ICODE_W  icode in E
- E_dstM_i  in  REG_W  E load destination
- e_Cnd_i  in  1  branch condition from E
- M_icode_i  in  ICODE_W  icode in M
- m_stat_i  in  STAT_W  M-stage status
- m_busy_i  in  1  data memory not ready; M must hold
- W_stat_i  in  STAT_W  W-stage status
- F_stall_o  out  1  hold F
- D_stall_o  out  1  hold D
- D_bubble_o  out  1  insert nop into D
- E_bubble_o  out  1  insert nop into E
- M_stall_o  out  1  hold M
- M_bubble_o  out  1  insert nop into M
- W_stall_o  out  1  hold W
- set_cc_o  out  1  CC write enable
- halted_o  out  1  core halted (sticky)
- stall_cnt_o  out  CNT_W  cycles with F_stall_o=1
- bubble_cnt_o  out  CNT_W  cycles with E_bubble_o=1

Behaviour:
- Definitions:
  - exc(s) = s∈{SADR,SINS,SHLT}.
  - lu = (E_icode∈{IMRMOVQ,IPOPQ}) & E_dstM≠RNONE & (E_dstM==d_srcA | E_dstM==d_srcB).
  - mp = E_icode==IJXX & ~e_Cnd.
  - rp = D/E/M_icode==IRET | ret_cnt≠0.
- State machine, registered state ∈ {RUN, DRAIN, HALTED}, reset to RUN:
  - RUN→DRAIN when exc(m_stat) & ~m_busy.
  - RUN→HALTED when exc(W_stat) (takes priority over RUN→DRAIN).
  - DRAIN→HALTED when exc(W_stat).
  - HALTED holds until rst_i.
- HALTED outputs: all stalls=1, all bubbles=0, set_cc=0, halted_o=1.
- DRAIN outputs: M_bubble=1, set_cc=0, F/D/E controls per RUN rules.
- Memory stall, RUN/DRAIN with m_busy=1 (highest priority below HALTED):
  - F, D, M, W stall = 1; E_bubble = 0; M_bubble = 0.
  - ret_cnt frozen.
  - Lower-priority hazards are masked this cycle.
- RUN/DRAIN with m_busy=0:
  - F_stall = lu | rp.
  - D_stall = lu.
  - D_bubble = mp | (~lu & rp).
  - E_bubble = mp | lu.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
  - M_stall = 0.
- set_cc = E_icode==IOPQ & state==RUN & ~exc(m_stat) & ~exc(W_stat) & ~m_busy.
- ret_cnt (4-bit, reset 0):
  - Loads RET_LAT on the cycle M_icode==IRET & ~m_busy.
  - Otherwise decrements when ≠0 and ~m_busy.
  - With RET_LAT=0 the behaviour matches the single-cycle ret rule.
- Counters, reset 0, saturating at all-ones:
  - stall_cnt increments each cycle F_stall_o=1 and state≠HALTED.
  - bubble_cnt increments each cycle E_bubble_o=1.
- Reset mid-operation: state, ret_cnt and counters clear immediately (asynchronous). During rst_i, outputs are those of RUN with zero counters, so they follow the combinational rules above.
- Simultaneous events:
  - mp together with rp: mp's bubbles dominate; F_stall still asserted by rp.
  - lu together with mp cannot occur in one E slot; no special handling.

Test Plan:
- Load-use: E_icode=IMRMOVQ, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; bubble_cnt +1.
- Mispredict: E_icode=IJXX, e_Cnd=0 → D_bubble=1, E_bubble=1, F_stall=0 (no ret in flight).
- Ret with RET_LAT=3: M_icode=IRET one cycle, then nops → F_stall=1 for 3 further cycles then 0; stall_cnt increases by 4 plus D/E ret cycles.
- Memory busy: m_busy=1 for 5 cycles during a ret countdown → F/D/M/W stall=1, ret_cnt frozen; countdown resumes after m_busy falls.
- Exception: m_stat=SADR while E_icode=IOPQ → set_cc=0, M_bubble=1, state DRAIN. Next cycle W_stat=SADR → halted_o=1, all stalls=1 until rst_i pulse; after reset halted_o=0 and counters=0.
- Saturation with CNT_W=4: hold load-use 20 cycles → stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_v2.sv
// Purpose: pipeline hazard / control unit for the 5-stage Y86-64 core (F/D/E/M/W).
// Latency: stage controls are combinational from stage state; mode, ret refill counter and perf counters are registered.
// Backpressure: m_busy_i freezes F/D/M/W and the ret countdown and masks all lower-priority hazards for that cycle.
//
// Ports:
//   clk_i, rst_i                 core clock, asynchronous active-high reset
//   D_icode_i, d_srcA_i/B_i      decode-stage icode and source registers
//   E_icode_i, E_dstM_i, e_Cnd_i execute-stage icode, load destination, branch outcome
//   M_icode_i, m_stat_i, m_busy_i memory-stage icode, status and data-memory wait
//   W_stat_i                     writeback-stage status
//   *_stall_o / *_bubble_o       per-stage hold / nop-insert controls
//   set_cc_o                     condition-code write enable
//   halted_o                     sticky halt indication
//   stall_cnt_o, bubble_cnt_o    saturating perf counters (F stall cycles, E bubble cycles)
module pipe_hazard_ctrl_v2 #(
    parameter int REG_W   = 4,
    parameter int ICODE_W = 4,
    parameter int STAT_W  = 3,
    parameter int RET_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ICODE_W-1:0] D_icode_i,
    input  logic [REG_W-1:0]   d_srcA_i,
    input  logic [REG_W-1:0]   d_srcB_i,
    input  logic [ICODE_W-1:0] E_icode_i,
    input  logic [REG_W-1:0]   E_dstM_i,
    input  logic               e_Cnd_i,
    input  logic [ICODE_W-1:0] M_icode_i,
    input  logic [STAT_W-1:0]  m_stat_i,
    input  logic               m_busy_i,
    input  logic [STAT_W-1:0]  W_stat_i,
    output logic               F_stall_o,
    output logic               D_stall_o,
    output logic               D_bubble_o,
    output logic               E_bubble_o,
    output logic               M_stall_o,
    output logic               M_bubble_o,
    output logic               W_stall_o,
    output logic               set_cc_o,
    output logic               halted_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    // Y86-64 encodings (match define.v)
    localparam logic [ICODE_W-1:0] IMRMOVQ = ICODE_W'(5);
    localparam logic [ICODE_W-1:0] IOPQ    = ICODE_W'(6);
    localparam logic [ICODE_W-1:0] IJXX    = ICODE_W'(7);
    localparam logic [ICODE_W-1:0] IRET    = ICODE_W'(9);
    localparam logic [ICODE_W-1:0] IPOPQ   = ICODE_W'(11);
    localparam logic [REG_W-1:0]   RNONE   = {REG_W{1'b1}};
    localparam logic [STAT_W-1:0]  SADR    = STAT_W'(2);
    localparam logic [STAT_W-1:0]  SINS    = STAT_W'(3);
    localparam logic [STAT_W-1:0]  SHLT    = STAT_W'(4);
    localparam logic [3:0]         RET_LD  = 4'(RET_LAT);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        ret_cnt;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    logic exc_m, exc_w, lu, mp, rp;

    function automatic logic is_exc(input logic [STAT_W-1:0] s);
        return (s == SADR) || (s == SINS) || (s == SHLT);
    endfunction

    assign exc_m = is_exc(m_stat_i);
    assign exc_w = is_exc(W_stat_i);

    // Load/use: a load in E feeds a register that decode is reading now.
    assign lu = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                (E_dstM_i != RNONE) &&
                ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign mp = (E_icode_i == IJXX) && !e_Cnd_i;
    // A ret anywhere in D/E/M, or the refill delay after it left M, blocks fetch.
    assign rp = (D_icode_i == IRET) || (E_icode_i == IRET) ||
                (M_icode_i == IRET) || (ret_cnt != 4'd0);

    // Next mode
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (exc_w)                   state_nxt = ST_HALTED;
                else if (exc_m && !m_busy_i) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (exc_w) state_nxt = ST_HALTED;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Stage controls
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_stall_o  = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b0;
        halted_o   = 1'b0;
        set_cc_o   = (E_icode_i == IOPQ) && (state == ST_RUN) &&
                     !exc_m && !exc_w && !m_busy_i;
        if (state == ST_HALTED) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
            halted_o  = 1'b1;
        end else if (m_busy_i) begin
            // Whole pipe holds while memory is outstanding; nothing is squashed.
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
        end else begin
            F_stall_o  = lu || rp;
            D_stall_o  = lu;
            // Mispredict squash dominates; a ret only bubbles D when D isn't held for load/use.
            D_bubble_o = mp || (!lu && rp);
            E_bubble_o = mp || lu;
            M_bubble_o = exc_m || exc_w || (state == ST_DRAIN);
            W_stall_o  = exc_w;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_RUN;
            ret_cnt    <= 4'd0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (!m_busy_i) begin
                if (M_icode_i == IRET)     ret_cnt <= RET_LD;
                else if (ret_cnt != 4'd0)  ret_cnt <= ret_cnt - 4'd1;
            end

            if (F_stall_o && (state != ST_HALTED) && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (E_bubble_o && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o  = stall_cnt;
    assign bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl_v2.sv
// Purpose: self-checking bench for pipe_hazard_ctrl_v2 (directed scenarios plus randomized traffic).
// Latency: compares combinational controls each cycle at the falling edge; counters after each rising edge.
// Backpressure: exercises m_busy holds, ret countdown freeze and the sticky halt path.
module tb_pipe_hazard_ctrl_v2;

    localparam int RET_LAT = 3;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPOPQ   = 4'd11;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd2;
    localparam logic [2:0] SINS    = 3'd3;
    localparam logic [2:0] SHLT    = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_Cnd, m_busy;
    logic [2:0] m_stat, W_stat;

    logic F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, set_cc, halted;
    logic [15:0] stall_cnt, bubble_cnt;
    logic s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_stall, s_M_bubble, s_W_stall, s_set_cc, s_halted;
    logic [3:0] s_stall_cnt, s_bubble_cnt;
    logic [8:0] dut_ctrl;

    assign dut_ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, set_cc, halted};

    // Reference model state
    int md_state;   // 0 run, 1 drain, 2 halted
    int md_ret;
    int raw_stall, raw_bubble;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_v2 #(.RET_LAT(RET_LAT), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
        .M_icode_i(M_icode), .m_stat_i(m_stat), .m_busy_i(m_busy), .W_stat_i(W_stat),
        .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble), .E_bubble_o(E_bubble),
        .M_stall_o(M_stall), .M_bubble_o(M_bubble), .W_stall_o(W_stall), .set_cc_o(set_cc),
        .halted_o(halted), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
    );

    pipe_hazard_ctrl_v2 #(.RET_LAT(RET_LAT), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
        .M_icode_i(M_icode), .m_stat_i(m_stat), .m_busy_i(m_busy), .W_stat_i(W_stat),
        .F_stall_o(s_F_stall), .D_stall_o(s_D_stall), .D_bubble_o(s_D_bubble), .E_bubble_o(s_E_bubble),
        .M_stall_o(s_M_stall), .M_bubble_o(s_M_bubble), .W_stall_o(s_W_stall), .set_cc_o(s_set_cc),
        .halted_o(s_halted), .stall_cnt_o(s_stall_cnt), .bubble_cnt_o(s_bubble_cnt)
    );

    function automatic logic exc(input logic [2:0] s);
        return (s == SADR) || (s == SINS) || (s == SHLT);
    endfunction

    function automatic int sat(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    // Expected {F_stall,D_stall,D_bubble,E_bubble,M_stall,M_bubble,W_stall,set_cc,halted}
    function automatic logic [8:0] exp_ctrl();
        logic lu, mp, rp, cc;
        lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp = (E_icode == IJXX) && !e_Cnd;
        rp = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET) || (md_ret > 0);
        cc = (E_icode == IOPQ) && (md_state == 0) && !exc(m_stat) && !exc(W_stat) && !m_busy;
        if (md_state == 2) return 9'b110010101;
        if (m_busy)        return 9'b110010100;
        return {lu | rp, lu, mp | (!lu & rp), mp | lu, 1'b0,
                exc(m_stat) | exc(W_stat) | (md_state == 1), exc(W_stat), cc, 1'b0};
    endfunction

    task automatic model_clear();
        md_state = 0; md_ret = 0; raw_stall = 0; raw_bubble = 0;
    endtask

    // Advance one clock and move the model with the inputs that were sampled.
    task automatic tick();
        logic [8:0] e;
        @(posedge clk);
        e = exp_ctrl();
        if (rst) begin
            model_clear();
        end else begin
            if (e[8] && md_state != 2) raw_stall++;
            if (e[5]) raw_bubble++;
            if (!m_busy) begin
                if (M_icode == IRET) md_ret = RET_LAT;
                else if (md_ret > 0) md_ret--;
            end
            if (md_state == 0) begin
                if (exc(W_stat)) md_state = 2;
                else if (exc(m_stat) && !m_busy) md_state = 1;
            end else if (md_state == 1) begin
                if (exc(W_stat)) md_state = 2;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        D_icode = INOP; d_srcA = RNONE; d_srcB = RNONE;
        E_icode = INOP; E_dstM = RNONE; e_Cnd = 1'b1;
        M_icode = INOP; m_stat = SAOK; m_busy = 1'b0; W_stat = SAOK;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dut_ctrl !== 9'b110100000) begin
            fails++; $display("FAIL reset_ctrl got %b want %b", dut_ctrl, 9'b110100000);
        end
        tests++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
            fails++; $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, s_stall_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        set_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b110100000) begin
            fails++; $display("FAIL lu_srcA got %b want %b", dut_ctrl, 9'b110100000);
        end
        tick();
        set_idle(); E_icode = IPOPQ; E_dstM = 4'd7; d_srcB = 4'd7;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b110100000) begin
            fails++; $display("FAIL lu_srcB got %b want %b", dut_ctrl, 9'b110100000);
        end
        tick();
        // RNONE destination never creates a hazard even when it matches
        set_idle(); E_icode = IMRMOVQ;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b000000000) begin
            fails++; $display("FAIL lu_rnone got %b want %b", dut_ctrl, 9'b000000000);
        end
        tick();
        set_idle();
        @(negedge clk); tests++;
        if (stall_cnt !== 16'd2 || bubble_cnt !== 16'd2) begin
            fails++; $display("FAIL lu_cnt got %0d/%0d want 2/2", stall_cnt, bubble_cnt);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        E_icode = IJXX; e_Cnd = 1'b0;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b001100000) begin
            fails++; $display("FAIL mp got %b want %b", dut_ctrl, 9'b001100000);
        end
        e_Cnd = 1'b1;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b000000000) begin
            fails++; $display("FAIL jxx_taken got %b want %b", dut_ctrl, 9'b000000000);
        end
        e_Cnd = 1'b0; D_icode = IRET;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b101100000) begin
            fails++; $display("FAIL mp_rp got %b want %b", dut_ctrl, 9'b101100000);
        end
        tick();
        set_idle();
    endtask

    task automatic test_ret();
        do_reset();
        for (int c = 0; c < 3 + RET_LAT + 1; c++) begin
            set_idle();
            if (c == 0) D_icode = IRET;
            if (c == 1) E_icode = IRET;
            if (c == 2) M_icode = IRET;
            @(negedge clk); tests++;
            if (c < 3 + RET_LAT) begin
                if (dut_ctrl !== 9'b101000000) begin
                    fails++; $display("FAIL ret_c%0d got %b want %b", c, dut_ctrl, 9'b101000000);
                end
            end else if (dut_ctrl !== 9'b000000000) begin
                fails++; $display("FAIL ret_done got %b want %b", dut_ctrl, 9'b000000000);
            end
            tick();
        end
        @(negedge clk); tests++;
        if (stall_cnt !== 16'd6) begin
            fails++; $display("FAIL ret_cnt got %0d want 6", stall_cnt);
        end
    endtask

    task automatic test_mem_busy();
        do_reset();
        M_icode = IRET;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b101000000) begin
            fails++; $display("FAIL busy_ret got %b want %b", dut_ctrl, 9'b101000000);
        end
        tick();
        set_idle(); tick();
        for (int c = 0; c < 5; c++) begin
            set_idle(); m_busy = 1'b1; E_icode = IJXX; e_Cnd = 1'b0;
            @(negedge clk); tests++;
            if (dut_ctrl !== 9'b110010100) begin
                fails++; $display("FAIL busy_c%0d got %b want %b", c, dut_ctrl, 9'b110010100);
            end
            tick();
        end
        set_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); tests++;
            if (dut_ctrl !== ((c < 2) ? 9'b101000000 : 9'b000000000)) begin
                fails++; $display("FAIL busy_resume_c%0d got %b", c, dut_ctrl);
            end
            tick();
        end
        @(negedge clk); tests++;
        if (stall_cnt !== 16'd9 || bubble_cnt !== 16'd0 || s_stall_cnt !== 4'd9) begin
            fails++; $display("FAIL busy_cnt got %0d/%0d/%0d want 9/0/9", stall_cnt, bubble_cnt, s_stall_cnt);
        end
    endtask

    task automatic test_exception();
        do_reset();
        E_icode = IMRMOVQ; E_dstM = 4'd2; d_srcA = 4'd2;
        tick();
        set_idle(); E_icode = IOPQ;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b000000010) begin
            fails++; $display("FAIL opq_cc got %b want %b", dut_ctrl, 9'b000000010);
        end
        tick();
        m_stat = SADR;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b000001000) begin
            fails++; $display("FAIL exc_m got %b want %b", dut_ctrl, 9'b000001000);
        end
        tick();
        m_stat = SAOK; W_stat = SADR;
        @(negedge clk); tests++;
        if (dut_ctrl !== 9'b000001100) begin
            fails++; $display("FAIL drain got %b want %b", dut_ctrl, 9'b000001100);
        end
        tick();
        set_idle(); E_icode = IOPQ;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); tests++;
            if (dut_ctrl !== 9'b110010101) begin
                fails++; $display("FAIL halted_c%0d got %b want %b", c, dut_ctrl, 9'b110010101);
            end
            tick();
        end
        @(negedge clk); tests++;
        if (stall_cnt !== 16'd1 || bubble_cnt !== 16'd1) begin
            fails++; $display("FAIL halt_cnt got %0d/%0d want 1/1", stall_cnt, bubble_cnt);
        end
        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        model_clear();
        #1; tests++;
        if (halted !== 1'b0 || stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            fails++; $display("FAIL arst got h=%b %0d/%0d want 0 0/0", halted, stall_cnt, bubble_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        set_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); tests++;
            if (s_stall_cnt !== 4'(sat(c, 15))) begin
                fails++; $display("FAIL sat_c%0d got %0d want %0d", c, s_stall_cnt, sat(c, 15));
            end
            tick();
        end
        @(negedge clk); tests++;
        if (s_stall_cnt !== 4'd15 || s_bubble_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
            fails++; $display("FAIL sat_end got %0d/%0d/%0d want 15/15/20", s_stall_cnt, s_bubble_cnt, stall_cnt);
        end
        set_idle();
    endtask

    task automatic test_random();
        int halt_cycles;
        logic [8:0] e;
        do_reset();
        halt_cycles = 0;
        for (int n = 0; n < 2000; n++) begin
            if (halt_cycles > 4 || $urandom_range(0, 299) == 0) begin
                do_reset();
                halt_cycles = 0;
            end
            D_icode = 4'($urandom_range(0, 11));
            d_srcA  = 4'($urandom_range(0, 15));
            d_srcB  = 4'($urandom_range(0, 15));
            E_icode = ($urandom_range(0, 3) == 0) ? IMRMOVQ : 4'($urandom_range(0, 11));
            E_dstM  = ($urandom_range(0, 2) == 0) ? d_srcA : 4'($urandom_range(0, 15));
            e_Cnd   = 1'($urandom_range(0, 1));
            M_icode = ($urandom_range(0, 7) == 0) ? IRET : 4'($urandom_range(0, 11));
            m_stat  = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
            W_stat  = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
            m_busy  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            e = exp_ctrl();
            tests++;
            if (dut_ctrl !== e) begin
                fails++; $display("FAIL rnd_ctrl n=%0d got %b want %b", n, dut_ctrl, e);
            end
            tests++;
            if (stall_cnt !== 16'(sat(raw_stall, 65535)) || bubble_cnt !== 16'(sat(raw_bubble, 65535)) ||
                s_stall_cnt !== 4'(sat(raw_stall, 15)) || s_bubble_cnt !== 4'(sat(raw_bubble, 15))) begin
                fails++;
                $display("FAIL rnd_cnt n=%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n,
                         stall_cnt, bubble_cnt, s_stall_cnt, s_bubble_cnt,
                         sat(raw_stall, 65535), sat(raw_bubble, 65535), sat(raw_stall, 15), sat(raw_bubble, 15));
            end
            if (md_state == 2) halt_cycles++;
            tick();
        end
        set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_idle();
        model_clear();
        test_reset();
        test_load_use();
        test_mispredict();
        test_ret();
        test_mem_busy();
        test_exception();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
